scan_chain_ctrl: RTL and testbench
==================================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, number of scan flops in the driven chain (2..1024).
REQ-002 SHALL have parameter CNT_W, default $clog2(CHAIN_LEN)+1, shift-counter width.
REQ-003 SHALL have port CK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port START  input  1  request one load/capture/unload sequence.
REQ-006 SHALL have port PAT  input  CHAIN_LEN  stimulus pattern, sampled when START is accepted.
REQ-007 SHALL have port SO  input  1  scan-out of the last chain flop.
REQ-008 SHALL have port SE  output  1  scan enable to every chain flop, registered.
REQ-009 SHALL have port SI  output  1  scan-in to the first chain flop, registered.
REQ-010 SHALL have port BUSY  output  1  sequence in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse; RESP valid.
REQ-012 SHALL have port RESP  output  CHAIN_LEN  unloaded response, held until the next accepted START.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CAPTURE, UNLOAD, FIN.
REQ-014 SHALL accept START only in IDLE; in all other states START is ignored.
REQ-015 SHALL, on acceptance, latch PAT into a shift register, clear the counter, and enter LOAD on the next edge.
REQ-016 SHALL, in LOAD, drive SE=1 and SI=PAT[k] in LOAD cycle k (k=0..CHAIN_LEN-1, LSB first), then enter CAPTURE.
REQ-017 SHALL, in CAPTURE, drive SE=0 and SI=0 for exactly one cycle, then enter UNLOAD.
REQ-018 SHALL, in UNLOAD, drive SE=1 and SI=0 for CHAIN_LEN cycles, shifting SO sampled in unload cycle k into RESP[k].
REQ-019 SHALL, after the last UNLOAD cycle, enter FIN, assert DONE for one cycle, and return to IDLE.
REQ-020 SHALL keep latency from the START-accept edge to DONE high at exactly 2*CHAIN_LEN+2 cycles.
REQ-021 SHALL assert BUSY in LOAD, CAPTURE and UNLOAD, and deassert it in IDLE and FIN.
REQ-022 SHALL accept a START asserted in the FIN cycle is ignored; START in the following IDLE cycle SHALL be accepted.
REQ-023 SHALL terminate the counter at CHAIN_LEN-1 without wrap; the counter SHALL never exceed CHAIN_LEN-1.

Reset
REQ-024 SHALL, on RST high, asynchronously force state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, counter=0.
REQ-025 SHALL, on RST asserted mid-sequence, abandon the sequence with no DONE pulse; the first START after RST falls SHALL begin a fresh sequence.

Configuration
REQ-026 SHALL, with macro SCAN_CTRL_MISR_EN defined, add output SIG (16 bits): a MISR (poly x^16+x^12+x^5+1) seeded 16'hFFFF at START-accept, updated with SO each UNLOAD cycle, and held after DONE.
REQ-027 SHALL, without SCAN_CTRL_MISR_EN, have no SIG port and no MISR logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum, the MISR polynomial and the seed constants in package scan_ctrl_pkg.
REQ-029 SHALL implement the MISR as sub-module scan_misr, instantiated only under SCAN_CTRL_MISR_EN.

Verification
Each scenario uses CHAIN_LEN=4 and a 4-flop chain model whose functional D is the inverse of its own Q.
REQ-030 SHALL cover: PAT=4'b1011, START pulse -> SI sequence 1,1,0,1 with SE=1; one SE=0 cycle; RESP=4'b0100; DONE exactly 10 cycles after accept.
REQ-031 SHALL cover: START held high continuously -> back-to-back sequences, each DONE spaced 11 cycles apart, no START accepted while BUSY=1.
REQ-032 SHALL cover: RST pulsed in UNLOAD cycle 2 -> SE=0, BUSY=0, RESP=0 immediately, no DONE; the next START yields a correct RESP.
REQ-033 SHALL cover: PAT=4'b0000, then 4'b1111 -> RESP=4'b1111, then 4'b0000; RESP stable between DONE and the next accept.
REQ-034 SHALL cover: SCAN_CTRL_MISR_EN with PAT=4'b1011 -> SIG matches the reference-model MISR over SO bits 0,0,1,0 from seed 16'hFFFF.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller: FSM state encoding
// and the response MISR polynomial, seed and single-step update.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StUnload,
    StFin
  } state_e;

  // x^16 + x^12 + x^5 + 1, x^16 implied by the shift-out of bit 15
  localparam logic [15:0] MisrPoly = 16'h1021;
  localparam logic [15:0] MisrSeed = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MisrPoly : 16'h0000);
  endfunction

endpackage

// File: rtl/scan_misr.sv
// 16-bit single-input signature register compacting the unloaded scan response.
// Reseeded on seed_i, advanced on en_i, otherwise holds.
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        seed_i,
  input  logic        en_i,
  input  logic        d_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed_i) begin
      sig_d = MisrSeed;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, d_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= MisrSeed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a pattern in, captures one cycle, shifts the response out.
// Optional SIG signature output is built when SCAN_CTRL_MISR_EN is defined.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP
`ifdef SCAN_CTRL_MISR_EN
  ,
  output logic [15:0]          SIG
`endif
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 done_q, done_d;
  logic                 accept;

  assign accept = (state_q == StIdle) && START;

  // SE/SI are registered, so each state's drive is computed one edge early,
  // including the first LOAD bit at the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    resp_d  = resp_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          cnt_d   = '0;
          pat_d   = PAT >> 1;
          resp_d  = '0;
          se_d    = 1'b1;
          si_d    = PAT[0];
        end
      end
      StLoad: begin
        if (cnt_q == CntLast) begin
          state_d = StCapture;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          se_d  = 1'b1;
          si_d  = pat_q[0];
          pat_d = pat_q >> 1;
        end
      end
      StCapture: begin
        state_d = StUnload;
        se_d    = 1'b1;
      end
      StUnload: begin
        // First SO sample ends up in RESP[0] after CHAIN_LEN shifts
        resp_d = {SO, resp_q[CHAIN_LEN-1:1]};
        if (cnt_q == CntLast) begin
          state_d = StFin;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          se_d  = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      done_q  <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign DONE = done_q;
  assign RESP = resp_q;
  assign BUSY = (state_q == StLoad) || (state_q == StCapture) || (state_q == StUnload);

`ifdef SCAN_CTRL_MISR_EN
  scan_misr u_misr (
    .clk_i  (CK),
    .rst_i  (RST),
    .seed_i (accept),
    .en_i   (state_q == StUnload),
    .d_i    (SO),
    .sig_o  (SIG)
  );
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-flop chain whose functional D is ~Q.
// Define SCAN_CTRL_MISR_EN to also check the SIG signature.
module tb_scan_chain_ctrl;

  localparam int unsigned N = 4;

  logic         ck = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] pat;
  logic         so, se, si, busy, done;
  logic [N-1:0] resp;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]  sig;
`endif

  logic [N-1:0] chain_q = '0;
  int           cyc = 0;

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] resp;
    bit           fin_poke;
  } vec_t;

  typedef struct {
    logic [N-1:0] resp;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;

  scan_chain_ctrl #(
    .CHAIN_LEN (N)
  ) dut (
    .CK    (ck),
    .RST   (rst),
    .START (start),
    .PAT   (pat),
    .SO    (so),
    .SE    (se),
    .SI    (si),
    .BUSY  (busy),
    .DONE  (done),
    .RESP  (resp)
`ifdef SCAN_CTRL_MISR_EN
   ,.SIG   (sig)
`endif
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  // Chain model: shift on SE, otherwise each flop captures its own inverse
  always @(posedge ck) begin
    if (se) chain_q <= {chain_q[N-2:0], si};
    else    chain_q <= ~chain_q;
  end
  assign so = chain_q[N-1];

  function automatic logic [15:0] ref_misr(input logic [N-1:0] bits);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int k = 0; k < int'(N); k++) begin
      fb = s[15] ^ bits[k];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for DONE on negedges, then pops the scoreboard and compares
  task automatic wait_done(input int budget);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ck);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: actual=no DONE required=DONE within %0d cycles", budget);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done: actual=DONE required=no DONE (cycle %0d)", cyc);
    end else begin
      e = sbq.pop_front();
      chk("resp", 32'(resp), 32'(e.resp));
      chk("done_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge ck);
    start  = 1'b1;
    pat    = v.pat;
    e.resp = v.resp;
    e.cyc  = cyc + 11;  // accept edge is cyc+1, DONE 10 edges later
    sbq.push_back(e);
    @(negedge ck);
    start = 1'b0;
    pat   = ~v.pat;  // only the accept-edge value may matter
    for (int k = 0; k < int'(N); k++) begin
      chk("load_se", 32'(se), 32'd1);
      chk("load_si", 32'(si), 32'(v.pat[k]));
      chk("load_busy", 32'(busy), 32'd1);
      @(negedge ck);
    end
    chk("cap_se", 32'(se), 32'd0);
    chk("cap_si", 32'(si), 32'd0);
    chk("cap_busy", 32'(busy), 32'd1);
    @(negedge ck);
    for (int k = 0; k < int'(N); k++) begin
      chk("unl_se", 32'(se), 32'd1);
      chk("unl_si", 32'(si), 32'd0);
      @(negedge ck);
    end
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_done", 32'(done), 32'd0);
    if (v.fin_poke) start = 1'b1;
    wait_done(15);
    start = 1'b0;
    chk("done_busy", 32'(busy), 32'd0);
`ifdef SCAN_CTRL_MISR_EN
    chk("sig", 32'(sig), 32'(ref_misr(v.resp)));
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      if (i == 0) chk("done_pulse_width", 32'(done), 32'd0);
      chk("resp_hold", 32'(resp), 32'(v.resp));
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   base;
    int   n_done;

    vecs[0] = '{pat: 4'b1011, resp: 4'b0100, fin_poke: 1'b0};
    vecs[1] = '{pat: 4'b0000, resp: 4'b1111, fin_poke: 1'b1};
    vecs[2] = '{pat: 4'b1111, resp: 4'b0000, fin_poke: 1'b0};
    vecs[3] = '{pat: 4'b0110, resp: 4'b1001, fin_poke: 1'b1};
    vecs[4] = '{pat: 4'b1000, resp: 4'b0111, fin_poke: 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    pat   = '0;
    repeat (2) @(negedge ck);
    chk("rst_se", 32'(se), 32'd0);
    chk("rst_si", 32'(si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // START held high: back-to-back sequences, DONE every 11 cycles
    @(negedge ck);
    start = 1'b1;
    pat   = 4'b0110;
    base  = cyc;
    for (int j = 0; j < 3; j++) begin
      e.resp = 4'b1001;
      e.cyc  = base + 11 + 11 * j;
      sbq.push_back(e);
    end
    for (int j = 0; j < 3; j++) begin
      wait_done(15);
      chk("held_done_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    repeat (2) @(negedge ck);
    chk("held_stopped_busy", 32'(busy), 32'd0);

    // Reset during UNLOAD cycle 2 abandons the sequence
    @(negedge ck);
    start = 1'b1;
    pat   = 4'b0000;
    @(negedge ck);
    start = 1'b0;
    repeat (7) @(negedge ck);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_resp", 32'(resp), 32'b1100);
    rst = 1'b1;
    #1;
    chk("midrst_se", 32'(se), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp", 32'(resp), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge ck);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge ck);
      if (done) n_done++;
    end
    chk("no_done_after_rst", 32'(n_done), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    run_vec(vecs[0]);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
